// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - dual-core bus responder sharing one single-port 64-bit RAM
module mem_bus_responder #(
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic        Clock,
  input  logic        nReset,
  inout  wire  [63:0] Data,
  inout  wire  [63:0] Data2,
  input  logic        nME,
  input  logic        nME2,
  input  logic        nALE,
  input  logic        nALE2,
  input  logic        RnW,
  input  logic        RnW2,
  input  logic        nOE,
  input  logic        nOE2,
  output logic        nRdy,
  output logic        nRdy2,
  output logic        Err,
  output logic        Err2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  // WAIT is entered with RD_LAT-1 loaded and leaves when the count hits zero
  localparam logic [1:0] LAT_LOAD = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  // Per-port views of the two core interfaces, index 0 = core 0, 1 = core 1
  logic        w_me_n    [2];
  logic        w_ale_n   [2];
  logic        w_rnw_in  [2];
  logic        w_oe_n    [2];
  logic [63:0] w_bus_in  [2];
  logic        w_drive   [2];

  state_t      r_state     [2];
  state_t      w_state_nxt [2];
  logic [53:0] r_addr      [2];
  logic        r_rnw       [2];
  logic [63:0] r_wdata     [2];
  logic [63:0] r_rdata     [2];
  logic        r_err       [2];
  logic [1:0]  r_cnt       [2];

  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_gnt_sel;
  logic [53:0]   w_gnt_addr;
  logic          w_oor;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_ram_rd;
  logic          r_last;

  logic [63:0] r_mem [0:(1<<AW)-1];

  assign w_me_n[0]   = nME;
  assign w_me_n[1]   = nME2;
  assign w_ale_n[0]  = nALE;
  assign w_ale_n[1]  = nALE2;
  assign w_rnw_in[0] = RnW;
  assign w_rnw_in[1] = RnW2;
  assign w_oe_n[0]   = nOE;
  assign w_oe_n[1]   = nOE2;
  assign w_bus_in[0] = Data;
  assign w_bus_in[1] = Data2;

  // A port competes for the RAM only while in REQ and the core still holds nME low
  assign w_req[0] = (r_state[0] == S_REQ) && !w_me_n[0];
  assign w_req[1] = (r_state[1] == S_REQ) && !w_me_n[1];

  // Round-robin: on a tie the port that was not granted last wins
  assign w_gnt[0] = w_req[0] && (!w_req[1] || r_last);
  assign w_gnt[1] = w_req[1] && (!w_req[0] || !r_last);

  assign w_gnt_sel  = w_gnt[1];
  assign w_gnt_addr = r_addr[w_gnt_sel];
  assign w_oor      = |w_gnt_addr[53:AW];
  assign w_idx      = w_gnt_addr[AW-1:0];
  assign w_ram_rd   = r_mem[w_idx];

  // Read data goes onto a bus only in DONE of a read with the core enabling output
  assign w_drive[0] = (r_state[0] == S_DONE) && r_rnw[0] && !w_me_n[0] && !w_oe_n[0];
  assign w_drive[1] = (r_state[1] == S_DONE) && r_rnw[1] && !w_me_n[1] && !w_oe_n[1];

  assign Data  = w_drive[0] ? r_rdata[0] : 64'bz;
  assign Data2 = w_drive[1] ? r_rdata[1] : 64'bz;

  assign nRdy  = (r_state[0] != S_DONE);
  assign nRdy2 = (r_state[1] != S_DONE);
  assign Err   = r_err[0];
  assign Err2  = r_err[1];

  // Next-state logic for both port FSMs
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_state_nxt[p] = r_state[p];
      case (r_state[p])
        S_IDLE: if (!w_me_n[p] && !w_ale_n[p]) w_state_nxt[p] = S_ADDR;
        S_ADDR: begin
          if (w_me_n[p])       w_state_nxt[p] = S_IDLE;
          else if (w_ale_n[p]) w_state_nxt[p] = S_REQ;
        end
        S_REQ: begin
          if (w_me_n[p])     w_state_nxt[p] = S_IDLE;
          else if (w_gnt[p]) w_state_nxt[p] = (RD_LAT == 0) ? S_DONE : S_WAIT;
        end
        S_WAIT: if (r_cnt[p] == 2'd0) w_state_nxt[p] = S_DONE;
        S_DONE: if (w_me_n[p]) w_state_nxt[p] = S_IDLE;
        default: w_state_nxt[p] = S_IDLE;
      endcase
    end
  end

  // State registers for both port FSMs
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state[0] <= S_IDLE;
      r_state[1] <= S_IDLE;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  // Per-port address/data capture, error flag and latency counter
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int p = 0; p < 2; p++) begin
        r_addr[p]  <= '0;
        r_rnw[p]   <= 1'b0;
        r_wdata[p] <= '0;
        r_rdata[p] <= '0;
        r_err[p]   <= 1'b0;
        r_cnt[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        case (r_state[p])
          S_IDLE: begin
            if (!w_me_n[p] && !w_ale_n[p]) begin
              r_addr[p] <= w_bus_in[p][53:0];
              r_rnw[p]  <= w_rnw_in[p];
            end
          end
          S_ADDR: begin
            if (!w_me_n[p] && w_ale_n[p] && !r_rnw[p]) r_wdata[p] <= w_bus_in[p];
          end
          S_REQ: begin
            if (w_gnt[p]) begin
              r_err[p] <= w_oor;
              r_cnt[p] <= LAT_LOAD;
              if (r_rnw[p]) r_rdata[p] <= w_oor ? 64'h0 : w_ram_rd;
            end
          end
          S_WAIT: r_cnt[p] <= r_cnt[p] - 2'd1;
          S_DONE: if (w_me_n[p]) r_err[p] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Arbiter pointer remembers which port got the most recent grant
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)     r_last <= 1'b1;
    else if (|w_gnt) r_last <= w_gnt[1];
  end

  // RAM write port; out-of-range writes are dropped, contents survive reset
  always_ff @(posedge Clock) begin
    if ((|w_gnt) && !r_rnw[w_gnt_sel] && !w_oor) r_mem[w_idx] <= r_wdata[w_gnt_sel];
  end

endmodule
